signal_generator: RTL and testbench

Programmable square-wave source that is the transmit-side counterpart of the frequency counter. It takes a two-digit BCD edge count N (0..99) and emits exactly N rising edges on `signal` in every measurement window of UPDATE_PERIOD+1 clock cycles. It drives the counter's `signal` input for on-chip loopback test and serves as a standalone test-tone output on the PMOD. Conversion and rate derivation use sequential repeated add/subtract, with no multiplier or divider.

---
 rtl/signal_generator.sv | 145 ++++++++++++++
 tb/tb_signal_generator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/signal_generator.sv
// Programmable square-wave source: emits exactly N rising edges per window of
// UPDATE_PERIOD+1 cycles, N loaded as two BCD digits.
module signal_generator #(
    parameter int UPDATE_PERIOD = 1200,
    parameter int BITS          = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] ten_count,
    input  logic [3:0] unit_count,
    output logic       signal,
    output logic       busy,
    output logic       window_done
);

    typedef enum logic [1:0] {IDLE, CONVERT, DIVIDE, RUN} state_t;

    localparam logic [BITS-1:0] LAST_WC   = BITS'(UPDATE_PERIOD);
    localparam logic [BITS:0]   REM_START = (BITS+1)'(UPDATE_PERIOD);

    state_t          state_q;
    logic [3:0]      tens_left_q;
    logic [3:0]      units_q;
    logic [6:0]      target_q;
    logic [BITS:0]   rem_q;
    logic [BITS-1:0] half_q;
    logic [BITS-1:0] wc_q;
    logic [BITS-1:0] pc_q;
    logic [6:0]      edges_q;
    logic            signal_q;
    logic            busy_q;
    logic            window_done_q;

    logic [3:0]      tens_clamped;
    logic [3:0]      units_clamped;
    logic [BITS:0]   two_target;
    logic [BITS:0]   period_last;
    logic [BITS-1:0] wc_d;
    logic [BITS-1:0] pc_inc;
    logic            wc_wrap;
    logic            pc_wrap;

    always_comb begin
        tens_clamped  = (ten_count  > 4'd9) ? 4'd9 : ten_count;
        units_clamped = (unit_count > 4'd9) ? 4'd9 : unit_count;
        two_target    = {{(BITS-7){1'b0}}, target_q, 1'b0};
        period_last   = {half_q, 1'b0} - (BITS+1)'(1);
        wc_wrap       = (wc_q == LAST_WC);
        wc_d          = wc_wrap ? '0 : wc_q + BITS'(1);
        pc_inc        = pc_q + BITS'(1);
        pc_wrap       = ({1'b0, pc_q} == period_last);
    end

    // load outranks every state; each branch below is one state's per-cycle step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            tens_left_q   <= '0;
            units_q       <= '0;
            target_q      <= '0;
            rem_q         <= '0;
            half_q        <= '0;
            wc_q          <= '0;
            pc_q          <= '0;
            edges_q       <= '0;
            signal_q      <= 1'b0;
            busy_q        <= 1'b0;
            window_done_q <= 1'b0;
        end else if (load) begin
            state_q       <= CONVERT;
            tens_left_q   <= tens_clamped;
            units_q       <= units_clamped;
            target_q      <= '0;
            signal_q      <= 1'b0;
            busy_q        <= 1'b1;
            window_done_q <= 1'b0;
        end else begin
            case (state_q)
                CONVERT: begin
                    if (tens_left_q != 4'd0) begin
                        target_q    <= target_q + 7'd10;
                        tens_left_q <= tens_left_q - 4'd1;
                    end else begin
                        target_q <= target_q + {3'b000, units_q};
                        rem_q    <= REM_START;
                        half_q   <= '0;
                        state_q  <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (target_q == 7'd0) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        signal_q <= 1'b0;
                    end else if (rem_q >= two_target) begin
                        rem_q  <= rem_q - two_target;
                        half_q <= half_q + BITS'(1);
                    end else begin
                        state_q       <= RUN;
                        busy_q        <= 1'b0;
                        wc_q          <= '0;
                        pc_q          <= '0;
                        edges_q       <= 7'd1;
                        signal_q      <= 1'b1;
                        window_done_q <= 1'b0;
                    end
                end
                RUN: begin
                    wc_q          <= wc_d;
                    window_done_q <= (wc_d == LAST_WC);
                    if (wc_wrap) begin
                        pc_q     <= '0;
                        edges_q  <= 7'd1;
                        signal_q <= 1'b1;
                    end else if (pc_wrap) begin
                        pc_q <= '0;
                        // once N pulses have started, the rest of the window stays low
                        if (edges_q < target_q) begin
                            edges_q  <= edges_q + 7'd1;
                            signal_q <= 1'b1;
                        end else begin
                            signal_q <= 1'b0;
                        end
                    end else begin
                        pc_q <= pc_inc;
                        if (pc_inc == half_q) begin
                            signal_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    signal_q      <= 1'b0;
                    busy_q        <= 1'b0;
                    window_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign signal      = signal_q;
    assign busy        = busy_q;
    assign window_done = window_done_q;

endmodule

// File: tb/tb_signal_generator.sv
// Scoreboard bench for signal_generator: loads push expected busy lengths and
// per-window pulse summaries; a negedge monitor measures and compares them.
module tb_signal_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] tenCount;
    logic [3:0] unitCount;
    logic       signalOut;
    logic       busy;
    logic       windowDone;

    signal_generator #(.UPDATE_PERIOD(1200), .BITS(12)) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .ten_count(tenCount),
        .unit_count(unitCount),
        .signal(signalOut),
        .busy(busy),
        .window_done(windowDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        int edges;
        int high;
        int lastFall;
    } winExp_t;

    winExp_t winQ[$];
    int      busyQ[$];
    int      checks = 0;
    int      passes = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    bit inBusy  = 1'b0;
    bit running = 1'b0;
    bit prevSig = 1'b0;
    int busyLen, wcM, edgeCnt, curHigh, minHigh, maxHigh, lastFall;

    task automatic startWindow();
        edgeCnt  = 0;
        curHigh  = 0;
        minHigh  = 99999;
        maxHigh  = 0;
        lastFall = -1;
    endtask

    task automatic sampleRun();
        winExp_t e;
        if (signalOut && !prevSig) begin
            edgeCnt++;
            curHigh = 1;
        end else if (signalOut) begin
            curHigh++;
        end else if (prevSig) begin
            if (curHigh < minHigh) minHigh = curHigh;
            if (curHigh > maxHigh) maxHigh = curHigh;
            lastFall = wcM;
        end
        prevSig = signalOut;
        if (windowDone) begin
            checkOutput("window_done index", wcM, 1200);
            if (winQ.size() == 0) begin
                checkOutput("unexpected window edges", edgeCnt, -1);
            end else begin
                e = winQ.pop_front();
                checkOutput("edges per window", edgeCnt, e.edges);
                checkOutput("min high length", minHigh, e.high);
                checkOutput("max high length", maxHigh, e.high);
                checkOutput("last fall index", lastFall, e.lastFall);
            end
            wcM = 0;
            startWindow();
        end else begin
            wcM++;
        end
    endtask

    // monitor: busy phases and RUN windows are measured here, independent of stimulus
    always @(negedge clk) begin
        if (reset) begin
            inBusy  = 1'b0;
            running = 1'b0;
        end else begin
            if (busy) begin
                if (!inBusy) begin
                    inBusy  = 1'b1;
                    busyLen = 0;
                    running = 1'b0;
                end
                busyLen++;
            end else begin
                if (inBusy) begin
                    inBusy = 1'b0;
                    if (busyQ.size() == 0) checkOutput("unexpected busy phase", busyLen, -1);
                    else checkOutput("busy length", busyLen, busyQ.pop_front());
                    running = 1'b1;
                    wcM     = 0;
                    prevSig = 1'b0;
                    startWindow();
                end
                if (running) sampleRun();
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] t, input logic [3:0] u, input int busyExp,
                                 input int n, input int h, input int windows);
        winExp_t e;
        if (busyExp >= 0) busyQ.push_back(busyExp);
        for (int i = 0; i < windows; i++) begin
            e.edges    = n;
            e.high     = h;
            e.lastFall = 2 * h * n - h;
            winQ.push_back(e);
        end
        @(negedge clk);
        tenCount  = t;
        unitCount = u;
        load      = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic waitWindows(input int n);
        int seen   = 0;
        int budget = n * 1201 + 1000;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            if (windowDone) seen++;
            budget--;
        end
        if (seen < n) checkOutput("window timeout", seen, n);
    endtask

    task automatic idleCheck(input string name, input int cycles);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (signalOut || busy || windowDone) bad++;
        end
        checkOutput(name, bad, 0);
    endtask

    initial begin
        int budget;
        reset     = 1'b1;
        load      = 1'b0;
        tenCount  = 4'd0;
        unitCount = 4'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset signal", int'(signalOut), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset window_done", int'(windowDone), 0);
        reset = 1'b0;

        // N = 23: H = 26, busy = 3 convert + 27 divide cycles
        applyStimulus(4'd2, 4'd3, 30, 23, 26, 2);
        waitWindows(2);

        // abort mid-pulse with N = 50 (H = 12)
        repeat (300) @(negedge clk);
        budget = 200;
        prevSig = prevSig;
        while (!(signalOut && budget < 200 && budget > 0 && !busy) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("signal high before abort", int'(signalOut), 1);
        applyStimulus(4'd5, 4'd0, 19, 50, 12, 1);
        checkOutput("abort signal low", int'(signalOut), 0);
        checkOutput("abort busy high", int'(busy), 1);
        waitWindows(1);

        // N = 1: H = 600
        applyStimulus(4'd0, 4'd1, 602, 1, 600, 1);
        waitWindows(1);

        // N = 99: H = 6
        applyStimulus(4'd9, 4'd9, 17, 99, 6, 1);
        waitWindows(1);

        // out-of-range digits clamp to 99
        applyStimulus(4'hC, 4'hF, 17, 99, 6, 1);
        waitWindows(1);

        // N = 0: short busy, then permanently idle
        applyStimulus(4'd0, 4'd0, 2, 0, 0, 0);
        repeat (3) @(negedge clk);
        idleCheck("idle after zero load", 2500);

        // reset in the middle of DIVIDE
        applyStimulus(4'd2, 4'd3, -1, 23, 26, 0);
        repeat (10) @(posedge clk);
        #2;
        checkOutput("busy before reset", int'(busy), 1);
        reset = 1'b1;
        #1;
        checkOutput("async reset signal", int'(signalOut), 0);
        checkOutput("async reset busy", int'(busy), 0);
        checkOutput("async reset window_done", int'(windowDone), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idleCheck("idle after reset", 1500);

        checkOutput("pending busy expectations", busyQ.size(), 0);
        checkOutput("pending window expectations", winQ.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
